// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period codes, control tokens, TERC4 code table.
// Used by the channel encoder and every decoder channel instance.
package tmds_pkg;

  // Period codes as reported by the framer alongside each symbol
  typedef enum logic [1:0] {
    PERIOD_CTRL    = 2'b00,
    PERIOD_VIDEO   = 2'b01,
    PERIOD_ISLAND  = 2'b10,
    PERIOD_INVALID = 2'b11
  } period_e;

  // Lock qualification states of one channel
  typedef enum logic {
    LOCK_HUNT   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  // Control tokens, written q[9:0] with q[0] first on the wire
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // TERC4 code words indexed by the nibble they carry (index 0 is leftmost)
  localparam logic [0:15][9:0] TERC4_TABLE = {
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Result of matching a word against the four control tokens
  typedef struct packed {
    logic       hit;
    logic [1:0] bits;
  } ctrl_dec_t;

  // Map a 10-bit word to its {C1,C0} pair, hit=0 when it is not a token
  function automatic ctrl_dec_t ctrl_lookup(input logic [9:0] sym);
    ctrl_dec_t r;
    r.hit  = 1'b1;
    r.bits = 2'b00;
    case (sym)
      CTRL_TOKEN_00: r.bits = 2'b00;
      CTRL_TOKEN_01: r.bits = 2'b01;
      CTRL_TOKEN_10: r.bits = 2'b10;
      CTRL_TOKEN_11: r.bits = 2'b11;
      default:       r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_terc4_lut.sv
// TERC4 reverse lookup: 10-bit island symbol to {hit, nibble}.
// Purely combinational; a miss reports hit=0 and nibble=0.
module tmds_terc4_lut
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       hit,
  output logic [3:0] nibble
);

  // Search the shared table; entries are unique so at most one matches
  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (sym == TERC4_TABLE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: one 10-bit symbol per clklow cycle into video byte,
// control pair or TERC4 nibble, qualified by a per-channel lock FSM.
// Two register stages (input capture, decoded output) give 2-cycle latency.
// Optional feature macro: TMDS_DISPARITY_CHECK_EN adds a running-disparity
// tracker on video symbols and the disp_err output.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_CNT  = 8,
  parameter int ERR_LIMIT = 4,
  parameter int ERRCNT_W  = 16
)
(
  input  logic                clklow,
  input  logic                reset_n,
  input  logic                sym_valid,
  input  logic [9:0]          q_in,
  input  logic [1:0]          state,
  output logic [7:0]          pix_data,
  output logic [1:0]          H_VSync_Ctr,
  output logic [3:0]          aux_data,
  output logic                out_valid,
  output logic                locked,
  output logic                sym_err,
  output logic [ERRCNT_W-1:0] err_count
`ifdef TMDS_DISPARITY_CHECK_EN
  ,
  output logic                disp_err
`endif
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W = $clog2(ERR_LIMIT + 1);

  logic [1:0]  rst_sync;
  logic        rst_n;

  logic        in_valid;
  logic [9:0]  in_sym;
  period_e     in_period;

  ctrl_dec_t   ctrl_dec;
  logic        terc4_hit;
  logic [3:0]  terc4_nibble;
  logic [7:0]  vid_d;
  logic [7:0]  vid_byte;
  logic        sym_bad;
  logic        sym_err_next;

  lock_state_e      lock_state;
  logic [RUN_W-1:0] run_cnt;
  logic [BAD_W-1:0] bad_cnt;

  // Reset asserts immediately but releases only after two clklow edges
  always_ff @(posedge clklow or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Input stage: capture the symbol and the period it belongs to
  always_ff @(posedge clklow or negedge rst_n) begin
    if (!rst_n) begin
      in_valid  <= 1'b0;
      in_sym    <= 10'd0;
      in_period <= PERIOD_CTRL;
    end else begin
      in_valid <= sym_valid;
      if (sym_valid) begin
        in_sym    <= q_in;
        in_period <= period_e'(state);
      end
    end
  end

  assign ctrl_dec = ctrl_lookup(in_sym);

  tmds_terc4_lut u_terc4_lut (
    .sym    (in_sym),
    .hit    (terc4_hit),
    .nibble (terc4_nibble)
  );

  // Video decode: undo the optional inversion, then the XOR/XNOR chain
  always_comb begin
    vid_d       = in_sym[9] ? ~in_sym[7:0] : in_sym[7:0];
    vid_byte    = 8'd0;
    vid_byte[0] = vid_d[0];
    for (int i = 1; i < 8; i++) begin
      vid_byte[i] = in_sym[8] ? (vid_d[i] ^ vid_d[i-1]) : ~(vid_d[i] ^ vid_d[i-1]);
    end
  end

  // A symbol is bad when it does not belong to the code space of its period
  always_comb begin
    sym_bad = 1'b0;
    case (in_period)
      PERIOD_CTRL:   sym_bad = !ctrl_dec.hit;
      PERIOD_VIDEO:  sym_bad = ctrl_dec.hit;
      PERIOD_ISLAND: sym_bad = !terc4_hit;
      default:       sym_bad = 1'b1;
    endcase
  end

`ifdef TMDS_DISPARITY_CHECK_EN
  logic signed [7:0] disp_q;
  logic signed [7:0] disp_next;
  logic signed [8:0] disp_sum;
  logic [3:0]        sym_ones;
  logic              disp_bad;

  // Running disparity over video symbols, clamped so a bad stream cannot wrap
  always_comb begin
    sym_ones  = 4'($countones(in_sym));
    disp_sum  = {disp_q[7], disp_q} + $signed({4'b0000, sym_ones, 1'b0}) - 9'sd10;
    disp_next = disp_q;
    case (in_period)
      PERIOD_VIDEO: begin
        if (disp_sum > 9'sd64) begin
          disp_next = 8'sd64;
        end else if (disp_sum < -9'sd64) begin
          disp_next = -8'sd64;
        end else begin
          disp_next = disp_sum[7:0];
        end
      end
      PERIOD_CTRL, PERIOD_ISLAND: disp_next = 8'sd0;
      default: disp_next = disp_q;
    endcase
    disp_bad = (in_period == PERIOD_VIDEO) &&
               ((disp_next > 8'sd10) || (disp_next < -8'sd10));
  end

  // Disparity register and its error pulse, advanced once per symbol
  always_ff @(posedge clklow or negedge rst_n) begin
    if (!rst_n) begin
      disp_q   <= 8'sd0;
      disp_err <= 1'b0;
    end else begin
      disp_err <= in_valid && disp_bad;
      if (in_valid) begin
        disp_q <= disp_next;
      end
    end
  end

  assign sym_err_next = sym_bad | disp_bad;
`else
  assign sym_err_next = sym_bad;
`endif

  // Output stage: decoded fields update only on a good symbol of their period
  always_ff @(posedge clklow or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      sym_err     <= 1'b0;
      pix_data    <= 8'd0;
      H_VSync_Ctr <= 2'b00;
      aux_data    <= 4'h0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sym_err <= sym_err_next;
        case (in_period)
          PERIOD_CTRL: begin
            if (ctrl_dec.hit) H_VSync_Ctr <= ctrl_dec.bits;
          end
          PERIOD_VIDEO: begin
            if (!ctrl_dec.hit) pix_data <= vid_byte;
          end
          PERIOD_ISLAND: begin
            if (terc4_hit) aux_data <= terc4_nibble;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Lock FSM with run/bad counters and the saturating error counter
  always_ff @(posedge clklow or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= LOCK_HUNT;
      locked     <= 1'b0;
      run_cnt    <= '0;
      bad_cnt    <= '0;
      err_count  <= '0;
    end else if (in_valid) begin
      if (sym_err_next && (lock_state == LOCK_LOCKED) && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
      case (lock_state)
        LOCK_HUNT: begin
          if ((in_period == PERIOD_CTRL) && ctrl_dec.hit) begin
            if (run_cnt == RUN_W'(LOCK_CNT - 1)) begin
              lock_state <= LOCK_LOCKED;
              locked     <= 1'b1;
              run_cnt    <= '0;
              bad_cnt    <= '0;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end else begin
            run_cnt <= '0;
          end
        end
        LOCK_LOCKED: begin
          if (sym_err_next) begin
            if (bad_cnt == BAD_W'(ERR_LIMIT - 1)) begin
              lock_state <= LOCK_HUNT;
              locked     <= 1'b0;
              run_cnt    <= '0;
              bad_cnt    <= '0;
            end else begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end else begin
            bad_cnt <= '0;
          end
        end
        default: begin
          lock_state <= LOCK_HUNT;
          locked     <= 1'b0;
        end
      endcase
    end
  end

endmodule
